// File: rtl/counter_as_timer.sv
`timescale 1ns/100ps
// counter_as_timer: free-running modulo-(MAX+1) counter with a terminal-count tick
// Ports:
//   clk   - system clock, state updates on the rising edge
//   reset - asynchronous active-high reset, clears Q immediately
//   Q     - registered count, $clog2(MAX)+1 bits so it always holds MAX
//   tick  - high while Q == MAX, decoded straight from the register
module counter_as_timer #(
    parameter int MAX = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic [$clog2(MAX):0]   Q,
    output logic                   tick
);
    localparam int W = $clog2(MAX) + 1;
    localparam logic [W-1:0] TERM = W'(MAX);

    // >= rather than == so an out-of-range value (e.g. an upset) reloads 0
    always_ff @(posedge clk or posedge reset)
        if (reset) Q <= '0;
        else       Q <= (Q >= TERM) ? '0 : Q + W'(1);

    assign tick = (Q == TERM);
endmodule

// File: tb/tb_counter_as_timer.sv
`timescale 1ns/100ps
// tb_counter_as_timer: scoreboard bench over several MAX values sharing clock and reset
module tb_counter_as_timer;
    localparam int N = 6;

    function automatic int max_of(input int i);
        return i == 0 ? 1 : i == 1 ? 3 : i == 2 ? 4 : i == 3 ? 7 : i == 4 ? 8 : 16;
    endfunction

    typedef struct {
        string               name;
        logic [N-1:0][31:0]  q;
        logic [N-1:0]        t;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [31:0] q_a [N];
    logic        t_a [N];
    exp_t sb[$];
    event async_ev;
    int checks = 0;
    int errors = 0;
    int n = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : u
        localparam int M = max_of(g);
        logic [$clog2(M):0] q;
        logic t;
        counter_as_timer #(.MAX(M)) dut (.clk(clk), .reset(reset), .Q(q), .tick(t));
        assign q_a[g] = 32'(q);
        assign t_a[g] = t;
    end

    // Model: after release the count is simply edges-since-release modulo MAX+1
    task automatic push(input string nm);
        exp_t e;
        e.name = nm;
        for (int i = 0; i < N; i++) begin
            e.q[i] = 32'(n % (max_of(i) + 1));
            e.t[i] = (n % (max_of(i) + 1)) == max_of(i);
        end
        sb.push_back(e);
    endtask

    task automatic step(input string nm);
        @(posedge clk);
        if (!reset) n++;
        push(nm);
    endtask

    // Asynchronous pulse placed between edges; checked while reset is still high
    task automatic async_pulse(input string nm);
        @(negedge clk);
        #($urandom_range(1, 2));
        reset = 1'b1;
        n = 0;
        #0.5;
        push(nm);
        -> async_ev;
        #0.5;
        reset = 1'b0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk or async_ev);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                for (int i = 0; i < N; i++) begin
                    checks++;
                    if (q_a[i] !== e.q[i]) begin
                        errors++;
                        $display("FAIL %s max=%0d Q got %0d want %0d", e.name, max_of(i), q_a[i], e.q[i]);
                    end
                    checks++;
                    if (t_a[i] !== e.t[i]) begin
                        errors++;
                        $display("FAIL %s max=%0d tick got %0b want %0b", e.name, max_of(i), t_a[i], e.t[i]);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1);
    end

    initial begin : stimulus
        int cnt [N];
        int lim;
        #1 reset = 1'b1;
        #0.5;
        push("async_reset");
        -> async_ev;
        #0.5 reset = 1'b0;
        for (int k = 0; k < 20; k++) step("sequence");
        lim = 0;
        while (n % 5 != 4 && lim < 5) begin
            step("to_terminal");
            lim++;
        end
        @(negedge clk);
        #1 reset = 1'b1;
        n = 0;
        #0.5;
        push("mid_count_reset");
        -> async_ev;
        #0.5 reset = 1'b0;
        for (int k = 0; k < 4; k++) step("restart");
        @(negedge clk);
        #1 reset = 1'b1;
        n = 0;
        #0.5;
        push("held_reset_enter");
        -> async_ev;
        for (int k = 0; k < 5; k++) step("held_reset");
        @(negedge clk);
        #1 reset = 1'b0;
        for (int k = 0; k < 3; k++) step("after_hold");
        for (int r = 0; r < 20; r++) begin
            lim = $urandom_range(1, 40);
            for (int k = 0; k < lim; k++) step("random_run");
            async_pulse("random_reset");
        end
        for (int i = 0; i < N; i++) cnt[i] = 0;
        for (int k = 0; k < 51; k++) begin
            step("bound_run");
            @(negedge clk);
            #1;
            for (int i = 0; i < N; i++) cnt[i] += int'(t_a[i]);
        end
        // Ticks land on edges M, 2M+1, ..., k(M+1)-1 counted from release
        for (int i = 0; i < N; i++) begin
            checks++;
            if (cnt[i] != 52 / (max_of(i) + 1)) begin
                errors++;
                $display("FAIL tick_count max=%0d got %0d want %0d", max_of(i), cnt[i], 52 / (max_of(i) + 1));
            end
        end
        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
